// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: the host transmitter FSM states, the frame parity helper
// and the common keyboard command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_START     = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a registered
// falling-edge pulse on the synchronized clock. Shared with the keyboard receiver.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic data_s1_q, data_s2_q;
   logic fall_q, fall_d;

   always_comb begin
      fall_d = clk_prev_q & ~clk_s2_q;
   end

   // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         clk_s1_q   <= clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         data_s1_q  <= data_in;
         data_s2_q  <= data_s1_q;
         fall_q     <= fall_d;
      end
   end

   assign clk_s    = clk_s2_q;
   assign data_s   = data_s2_q;
   assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, clocked-out frame,
// device acknowledge check, with a watchdog on the device clock.
//
// state     | meaning
// IDLE      | lines released, ready for a command byte
// INHIBIT   | clock held low to request to send
// START     | clock and data low (start bit) before clock release
// SHIFT     | device clocks out D0..D7, parity, stop
// ACK       | waiting for clock edge 11 to sample the acknowledge
// WAIT_IDLE | waiting for device to release both lines
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_CYCLES   = 250,
   parameter int TIMEOUT_CYCLES = 750_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int MAX_C = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
   localparam int TW    = $clog2(MAX_C + 1);

   if (CLK_HZ < 1) begin : g_clk_hz_invalid
      $error("CLK_HZ must be positive");
   end

   logic clk_s, data_s, clk_fall;

   ps2_line_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_in   (ps2_clk_in),
      .data_in  (ps2_data_in),
      .clk_s    (clk_s),
      .data_s   (data_s),
      .clk_fall (clk_fall)
   );

   ps2_state_e      state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [9:0]      shift_q, shift_d;
   logic [3:0]      nbit_q, nbit_d;
   logic            clk_oe_q, clk_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            timer_tc;

   assign timer_tc = (timer_q == '0);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      shift_d   = shift_q;
      nbit_d    = nbit_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               shift_d  = {1'b1, odd_parity(tx_data), tx_data};
               timer_d  = TW'(INHIBIT_CYCLES - 1);
               clk_oe_d = 1'b1;
               state_d  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (timer_tc) begin
               timer_d   = TW'(START_CYCLES - 1);
               data_oe_d = 1'b1;
               state_d   = ST_START;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_START: begin
            if (timer_tc) begin
               clk_oe_d = 1'b0;
               timer_d  = TW'(TIMEOUT_CYCLES - 1);
               nbit_d   = '0;
               state_d  = ST_SHIFT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b0, shift_q[9:1]};
               nbit_d    = nbit_q + 1'b1;
               timer_d   = TW'(TIMEOUT_CYCLES - 1);
               if (nbit_q == 4'd9) state_d = ST_ACK;
            end else if (timer_tc) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               timer_d = TW'(TIMEOUT_CYCLES - 1);
               if (!data_s) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  data_oe_d = 1'b0;
                  err_d     = 1'b1;
                  state_d   = ST_IDLE;
               end
            end else if (timer_tc) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_s && data_s) begin
               data_oe_d = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end else if (timer_tc) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         shift_q   <= '0;
         nbit_q    <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
         nbit_q    <= nbit_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a scripted PS/2 device, table of
// command frames, plus watchdog and asynchronous-reset sequences.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int STC = 5;
   localparam int TO  = 400;
   localparam int H   = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .CLK_HZ         (50_000_000),
      .INHIBIT_CYCLES (INH),
      .START_CYCLES   (STC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         poke;
      logic [9:0] frame;
      int         exp_done;
      int         exp_err;
   } vec_t;

   // Accept a byte; check inhibit/start timing; return cycle-aligned at clock release.
   task automatic request(input logic [7:0] d);
      int cnt;
      chk("ready_before", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("clk_oe_after_accept", ps2_clk_oe, 1);
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", tx_ready, 0);
      cnt = 0;
      while (!ps2_data_oe && cnt < 4 * INH) begin
         @(negedge clk);
         cnt++;
      end
      chk("inhibit_len", cnt, INH);
      cnt = 0;
      while (ps2_clk_oe && cnt < 4 * STC) begin
         @(negedge clk);
         cnt++;
      end
      chk("start_len", cnt, STC);
      chk("start_bit", ps2_data_oe, 1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [9:0] bits;
      int d0, e0, w;
      d0 = done_cnt;
      e0 = err_cnt;
      bits = '0;
      request(v.data);
      repeat (3) @(negedge clk);
      for (int n = 0; n < 10; n++) begin
         dev_clk_low = 1'b1;
         if (v.poke && n == 4) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (H - 1) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
         bits[n] = ~ps2_data_oe;
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clk);
      end
      chk("frame", bits, v.frame);
      if (v.ack) dev_data_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clk);
      dev_data_low = 1'b0;
      w = 0;
      while (done_cnt == d0 && err_cnt == e0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      repeat (5) @(negedge clk);
      chk("done_pulses", done_cnt - d0, v.exp_done);
      chk("err_pulses", err_cnt - e0, v.exp_err);
      chk("clk_oe_end", ps2_clk_oe, 0);
      chk("data_oe_end", ps2_data_oe, 0);
      chk("ready_end", tx_ready, 1);
      chk("busy_end", busy, 0);
   endtask

   vec_t vecs[6];

   initial begin
      int cnt, d0, e0;
      vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h3ED, 1, 0};
      vecs[1] = '{8'hF4, 1'b1, 1'b0, 10'h2F4, 1, 0};
      vecs[2] = '{8'hFF, 1'b0, 1'b0, 10'h3FF, 0, 1};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 10'h300, 1, 0};
      vecs[4] = '{8'hED, 1'b1, 1'b1, 10'h3ED, 1, 0};
      vecs[5] = '{8'h01, 1'b1, 1'b0, 10'h201, 1, 0};

      repeat (3) @(negedge clk);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Device never clocks after release: watchdog fires TO cycles later.
      e0 = err_cnt;
      d0 = done_cnt;
      request(8'hF4);
      cnt = 0;
      while (!err && cnt < 2 * TO) begin
         @(negedge clk);
         cnt++;
      end
      chk("timeout_len", cnt, TO);
      repeat (3) @(negedge clk);
      chk("timeout_err", err_cnt - e0, 1);
      chk("timeout_done", done_cnt - d0, 0);
      chk("timeout_clk_oe", ps2_clk_oe, 0);
      chk("timeout_data_oe", ps2_data_oe, 0);
      chk("timeout_ready", tx_ready, 1);

      // Reset after the fifth device clock edge: lines drop immediately, no pulses.
      e0 = err_cnt;
      d0 = done_cnt;
      request(8'hED);
      repeat (3) @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         if (n < 4) begin
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
         end
      end
      chk("pre_reset_data_oe", ps2_data_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clk_oe", ps2_clk_oe, 0);
      chk("async_data_oe", ps2_data_oe, 0);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_ready", tx_ready, 1);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_done", done_cnt - d0, 0);
      chk("post_reset_err", err_cnt - e0, 0);

      // A fresh command still completes after the mid-frame reset.
      run_vec(vecs[1]);
      chk("done_err_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
